// File: rtl/rx.sv
// Configurable asynchronous serial receiver.
// Frame: start bit (0), 7 or 8 data bits LSB first, optional parity bit,
// then 1 or 2 stop bits (1). The line is double-synchronized and sampled
// at mid-bit using a bit-period counter.
module rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop_bits,
  input  logic       data_width,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             line_prev_q, line_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_bit_q, parity_bit_d;
  logic             stop_bad_q, stop_bad_d;
  logic             ptype_q, ptype_d;
  logic             pen_q, pen_d;
  logic             stop2_q, stop2_d;
  logic             width8_q, width8_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             parity_error_q, parity_error_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_done_q, rx_done_d;

  logic fall_edge;
  logic sample_tick;
  logic last_bit;
  logic last_stop;
  logic stop_bad_now;

  // Decode of edge, mid-bit strobe and end-of-field conditions shared by FSM and datapath
  always_comb begin
    fall_edge    = line_prev_q & ~sync2_q;
    sample_tick  = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);
    last_bit     = (bit_idx_q == (width8_q ? 3'd7 : 3'd6));
    last_stop    = (stop_idx_q == stop2_q);
    stop_bad_now = stop_bad_q | ~sync2_q;
  end

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a falling edge is only recognised while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall_edge) state_d = START;
      START:   if (sample_tick) state_d = sync2_q ? IDLE : DATA;
      DATA:    if (sample_tick && last_bit) state_d = pen_q ? PARITY : STOP;
      PARITY:  if (sample_tick) state_d = STOP;
      STOP:    if (sample_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: synchronizer, bit counter, config capture, sampling and result latch
  always_comb begin
    sync1_d        = serial_in;
    sync2_d        = sync1_q;
    line_prev_d    = sync2_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    stop_idx_d     = stop_idx_q;
    shift_d        = shift_q;
    parity_bit_d   = parity_bit_q;
    stop_bad_d     = stop_bad_q;
    ptype_d        = ptype_q;
    pen_d          = pen_q;
    stop2_d        = stop2_q;
    width8_d       = width8_q;
    data_out_d     = data_out_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    rx_done_d      = 1'b0;

    if (state_q == IDLE)   cnt_d = '0;
    else if (sample_tick)  cnt_d = '0;
    else                   cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          ptype_d      = parity_type;
          pen_d        = parity_en;
          stop2_d      = stop_bits;
          width8_d     = data_width;
          shift_d      = '0;
          bit_idx_d    = '0;
          stop_idx_d   = 1'b0;
          parity_bit_d = 1'b0;
          stop_bad_d   = 1'b0;
        end
      end
      DATA: begin
        if (sample_tick) begin
          shift_d[bit_idx_q] = sync2_q;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (sample_tick) parity_bit_d = sync2_q;
      end
      STOP: begin
        if (sample_tick) begin
          stop_bad_d = stop_bad_now;
          stop_idx_d = 1'b1;
          if (last_stop) begin
            rx_done_d      = 1'b1;
            data_out_d     = shift_q;
            parity_error_d = pen_q & (^shift_q ^ parity_bit_q ^ ptype_q);
            frame_error_d  = stop_bad_now;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; synchronizer resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      line_prev_q    <= 1'b1;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      stop_idx_q     <= 1'b0;
      shift_q        <= '0;
      parity_bit_q   <= 1'b0;
      stop_bad_q     <= 1'b0;
      ptype_q        <= 1'b0;
      pen_q          <= 1'b0;
      stop2_q        <= 1'b0;
      width8_q       <= 1'b0;
      data_out_q     <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      rx_done_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      line_prev_q    <= line_prev_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      stop_idx_q     <= stop_idx_d;
      shift_q        <= shift_d;
      parity_bit_q   <= parity_bit_d;
      stop_bad_q     <= stop_bad_d;
      ptype_q        <= ptype_d;
      pen_q          <= pen_d;
      stop2_q        <= stop2_d;
      width8_q       <= width8_d;
      data_out_q     <= data_out_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      rx_done_q      <= rx_done_d;
    end
  end

  // Output decode: busy reflects any non-idle state, results come straight from flops
  always_comb begin
    busy         = (state_q != IDLE);
    data_out     = data_out_q;
    rx_done      = rx_done_q;
    parity_error = parity_error_q;
    frame_error  = frame_error_q;
  end

endmodule

// File: doc/rx.md
RX -- requirements
Module: rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit period; legal values are even and 4 or more.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 serial_in  input  1  asynchronous serial line; idles high.
REQ-005 parity_type  input  1  parity selection: 0 = even, 1 = odd.
REQ-006 parity_en  input  1  1 = a parity bit follows the data bits.
REQ-007 stop_bits  input  1  stop bit count: 0 = one stop bit, 1 = two stop bits.
REQ-008 data_width  input  1  data bit count: 0 = 7 data bits, 1 = 8 data bits.
REQ-009 data_out  output  8  last received data byte, LSB first on the line; bit 7 is 0 in 7-bit mode.
REQ-010 rx_done  output  1  one-cycle pulse that marks a completed frame.
REQ-011 parity_error  output  1  parity check result for the last frame.
REQ-012 frame_error  output  1  stop bit check result for the last frame.
REQ-013 busy  output  1  high whenever the FSM is outside IDLE.

Function
REQ-014 serial_in SHALL pass through a 2-flop synchronizer; all sampling below uses the synchronized signal.
REQ-015 Frame format SHALL be: start bit 0, data bits LSB first, optional parity bit, then 1 or 2 stop bits of value 1.
REQ-016 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START SHALL occur on a synchronized 1->0 transition; parity_type, parity_en, stop_bits and data_width are captured on that cycle and held for the whole frame.
REQ-018 In START, the line SHALL be sampled CLKS_PER_BIT/2 cycles after the edge.
REQ-019 If that START sample is 1, the FSM SHALL return to IDLE (false start) with no rx_done and no output change.
REQ-020 If that START sample is 0, the FSM SHALL go to DATA.
REQ-021 DATA, PARITY and STOP bits SHALL each be sampled every CLKS_PER_BIT cycles after the start mid-point sample, i.e. at mid-bit.
REQ-022 DATA SHALL collect 7 or 8 bits per captured data_width, then go to PARITY if parity_en was captured high, otherwise to STOP.
REQ-023 Parity check: the XOR of the data bits, the parity bit and parity_type SHALL be 0 for a good frame; parity_error is set to 1 otherwise.
REQ-024 parity_error SHALL be 0 when parity is disabled.
REQ-025 STOP SHALL sample 1 or 2 stop bits; frame_error is set to 1 if any stop sample is 0.
REQ-026 One cycle after the final stop sample, rx_done SHALL pulse for exactly 1 cycle; data_out, parity_error and frame_error update on that same cycle.
REQ-027 The FSM SHALL return to IDLE on the same cycle as the rx_done pulse.
REQ-028 data_out, parity_error and frame_error SHALL hold their values until the next rx_done.
REQ-029 After a frame_error, a new frame SHALL start only on a fresh 1->0 transition; a line stuck low produces no further frames.
REQ-030 The bit-period counter SHALL wrap to 0 at each mid-bit sample, never overflow, and be sized for CLKS_PER_BIT.
REQ-031 A falling edge seen during a frame SHALL be ignored; edge detection is active only in IDLE.
REQ-032 Changes to the configuration inputs mid-frame SHALL have no effect until the next start edge.

Reset
REQ-033 While rst_n = 0, the block SHALL be in IDLE with data_out = 0, rx_done = 0, parity_error = 0, frame_error = 0 and busy = 0.
REQ-034 While rst_n = 0, the synchronizer flops SHALL be 1 and all counters 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no rx_done.
REQ-036 After reset, reception SHALL resume only on a new falling edge.

Verification
REQ-037 CLKS_PER_BIT=4, 8N1, byte 0xA5 -> exactly one rx_done; data_out=0xA5, parity_error=0, frame_error=0.
REQ-038 8E1, byte 0x03 sent with parity bit 1 (wrong) -> rx_done; data_out=0x03, parity_error=1, frame_error=0.
REQ-039 7O2, data 0x41, correct odd parity bit 1, second stop bit driven 0 -> rx_done; data_out=0x41, parity_error=0, frame_error=1.
REQ-040 Low glitch of 1 clock on an idle line -> return to IDLE, no rx_done, busy low 2 bit-times later.
REQ-041 rst_n pulsed low during the 4th data bit, then a clean 0x5A frame -> no pulse for the aborted frame; a single rx_done with data_out=0x5A.
REQ-042 Two 8N1 frames back-to-back (0xFF then 0x00), no idle gap -> two rx_done pulses, values 0xFF then 0x00.
